// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU definitions for the multi-cycle sequencer: FSM state encoding,
// opcode constants and opcode classification helpers.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_INTR   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LIH  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_JAL  = 4'd5;
  localparam logic [3:0] OP_JCC  = 4'd6;

  // Opcodes that write x_rd in WB; 7-F are nops and never write.
  function automatic logic op_writes_rf(input logic [3:0] op);
    case (op)
      OP_LIH, OP_ADD, OP_ADDI, OP_LW, OP_JAL, OP_JCC: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/INTR).
// Owns the architectural PC, EPC and global interrupt enable, and muxes the
// single memory port between instruction fetch and data access.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   opcode              opcode of the latched instruction
//   ex_pc/ex_addr/ex_wdata  ALU results: next PC, data word address, store data
//   mem_rdata, mem_ack  memory response (rdata is consumed by IR/mem_val regs)
//   intr_req            level interrupt request, sampled only in WB
//   mem_req/mem_we/mem_addr/mem_wdata  memory request port
//   ir_en, ld_en, rf_we register load strobes
//   pc, epc, intr_en, state  architectural / debug state
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INTR_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic [31:0] ex_pc,
  input  logic [29:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        intr_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        ir_en,
  output logic        ld_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        intr_en,
  output logic [2:0]  state
);

  state_t      st, st_nxt;
  logic [31:0] pc_r, epc_r;
  logic        ien_r;

  // Read data goes straight to the IR / mem_val registers outside this block.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      pc_r  <= RESET_PC;
      epc_r <= 32'h0;
      ien_r <= 1'b1;
    end else begin
      st <= st_nxt;
      case (st)
        S_WB:    pc_r <= ex_pc;
        S_INTR: begin
          epc_r <= ex_pc;
          pc_r  <= INTR_VEC;
          ien_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_nxt    = st;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 30'h0;
    mem_wdata = 32'h0;
    ir_en     = 1'b0;
    ld_en     = 1'b0;
    rf_we     = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_r[31:2];
        if (mem_ack) begin
          ir_en  = 1'b1;
          st_nxt = S_DECODE;
        end
      end
      S_DECODE: st_nxt = S_EXEC;
      S_EXEC:   st_nxt = op_is_mem(opcode) ? S_MEM : S_WB;
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (opcode == OP_SW);
        mem_addr  = ex_addr;
        mem_wdata = ex_wdata;
        if (mem_ack) begin
          ld_en  = (opcode == OP_LW);
          st_nxt = S_WB;
        end
      end
      S_WB: begin
        rf_we  = op_writes_rf(opcode);
        st_nxt = (ien_r && intr_req) ? S_INTR : S_FETCH;
      end
      S_INTR:  st_nxt = S_FETCH;
      default: st_nxt = S_FETCH;
    endcase
    // Strobes and the memory port are silenced during the reset cycle, even
    // if the FSM is parked mid-transaction.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 30'h0;
      mem_wdata = 32'h0;
      ir_en     = 1'b0;
      ld_en     = 1'b0;
      rf_we     = 1'b0;
    end
  end

  assign pc      = pc_r;
  assign epc     = epc_r;
  assign intr_en = ien_r;
  assign state   = st;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. An instruction-level model expands
// each directed instruction into its expected per-cycle schedule; a single
// compare process checks the DUT against it on every falling edge.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] IVEC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic [31:0] ex_pc = 32'h0;
  logic [29:0] ex_addr = 30'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        intr_req = 1'b0;
  logic        mem_req, mem_we, ir_en, ld_en, rf_we, intr_en;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, pc, epc;
  logic [2:0]  state;

  cpu_sequencer #(.RESET_PC(RST_PC), .INTR_VEC(IVEC)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ex_pc(ex_pc),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .intr_req(intr_req), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ir_en(ir_en), .ld_en(ld_en), .rf_we(rf_we), .pc(pc), .epc(epc),
    .intr_en(intr_en), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack, intr;
    logic        mem_req, mem_we, ir_en, ld_en, rf_we, intr_en;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, pc, epc;
    logic [2:0]  state;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc = RST_PC, m_epc = 32'h0;
  logic        m_ien = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c = '{ack: 1'b0, intr: 1'b0, mem_req: 1'b0, mem_we: 1'b0, ir_en: 1'b0,
          ld_en: 1'b0, rf_we: 1'b0, intr_en: m_ien, mem_addr: 30'h0,
          mem_wdata: 32'h0, pc: m_pc, epc: m_epc, state: st};
    return c;
  endfunction

  // Expand one instruction into its cycle schedule and advance the model.
  // fw/mw: wait cycles before ack in fetch/memory; noise: ack and intr held
  // high in cycles where they must be ignored; abort: stop after that many
  // unacked MEM cycles (used before a mid-transaction reset).
  task automatic build(input logic [3:0] op, input logic [31:0] npc,
                       input logic [29:0] addr, input logic [31:0] wd,
                       input int fw, input int mw, input bit intr_wb,
                       input bit noise, input int abort);
    cyc_t c;
    int   n;
    q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = blank(S_FETCH); c.mem_req = 1; c.mem_addr = m_pc[31:2];
      c.ack = (i == fw); c.ir_en = c.ack; q.push_back(c);
    end
    c = blank(S_DECODE); c.ack = noise; c.intr = noise; q.push_back(c);
    c = blank(S_EXEC);   c.ack = noise; c.intr = noise; q.push_back(c);
    if (op == 4'd3 || op == 4'd4) begin
      n = (abort > 0) ? abort : mw + 1;
      for (int i = 0; i < n; i++) begin
        c = blank(S_MEM); c.mem_req = 1; c.mem_we = (op == 4'd3);
        c.mem_addr = addr; c.mem_wdata = wd;
        c.ack = (abort == 0) && (i == mw); c.ld_en = c.ack && (op == 4'd4);
        q.push_back(c);
      end
      if (abort > 0) return;
    end
    c = blank(S_WB);
    c.rf_we = (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
    c.intr = intr_wb; c.ack = noise; q.push_back(c);
    m_pc = npc;
    if (intr_wb && m_ien) begin
      c = blank(S_INTR); q.push_back(c);
      m_epc = npc; m_pc = IVEC; m_ien = 1'b0;
    end
  endtask

  task automatic play(input logic [3:0] op, input logic [31:0] npc,
                      input logic [29:0] addr, input logic [31:0] wd);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      reset = 0; opcode = op; ex_pc = npc; ex_addr = addr; ex_wdata = wd;
      mem_ack = q[i].ack; intr_req = q[i].intr; mem_rdata = $urandom;
      cur = q[i]; chk_en = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; mem_ack = 0; intr_req = 0; chk_en = 0;
    @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_ir_en",   {31'h0, ir_en},   32'h0);
    chk("rst_ld_en",   {31'h0, ld_en},   32'h0);
    chk("rst_rf_we",   {31'h0, rf_we},   32'h0);
    m_pc = RST_PC; m_epc = 32'h0; m_ien = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     {29'h0, state},     {29'h0, cur.state});
      chk("mem_req",   {31'h0, mem_req},   {31'h0, cur.mem_req});
      chk("mem_we",    {31'h0, mem_we},    {31'h0, cur.mem_we});
      chk("mem_addr",  {2'b0, mem_addr},   {2'b0, cur.mem_addr});
      chk("mem_wdata", mem_wdata,          cur.mem_wdata);
      chk("ir_en",     {31'h0, ir_en},     {31'h0, cur.ir_en});
      chk("ld_en",     {31'h0, ld_en},     {31'h0, cur.ld_en});
      chk("rf_we",     {31'h0, rf_we},     {31'h0, cur.rf_we});
      chk("pc",        pc,                 cur.pc);
      chk("epc",       epc,                cur.epc);
      chk("intr_en",   {31'h0, intr_en},   {31'h0, cur.intr_en});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ALU op, zero wait: 4 cycles, pc=4 after WB
    build(4'd1, 32'h4, 30'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("lit_alu_cycles", q.size(), 4);
    chk("lit_alu_wb_rfwe", {31'h0, q[3].rf_we}, 32'h1);
    chk("lit_alu_pc", m_pc, 32'h4);
    play(4'd1, 32'h4, 30'h0, 32'h0);

    // lw, 2 wait cycles in MEM: 7 cycles, ld_en only in ack cycle
    build(4'd4, 32'h8, 30'h10, 32'h0, 0, 2, 0, 0, 0);
    chk("lit_lw_cycles", q.size(), 7);
    chk("lit_lw_ld_ack", {31'h0, q[5].ld_en}, 32'h1);
    chk("lit_lw_addr", {2'b0, q[4].mem_addr}, 32'h10);
    play(4'd4, 32'h8, 30'h10, 32'h0);

    // sw with fetch and memory waits, stray ack/intr outside request states
    build(4'd3, 32'hC, 30'h22, 32'hDEADBEEF, 1, 1, 0, 1, 0);
    chk("lit_sw_cycles", q.size(), 7);
    chk("lit_sw_rfwe", {31'h0, q[6].rf_we}, 32'h0);
    play(4'd3, 32'hC, 30'h22, 32'hDEADBEEF);

    // nop opcode F: no MEM, no rf write, pc still advances
    build(4'hF, 32'h10, 30'h3, 32'h1, 0, 0, 0, 1, 0);
    chk("lit_nop_cycles", q.size(), 4);
    play(4'hF, 32'h10, 30'h3, 32'h1);

    // intr pulses outside WB are ignored
    build(4'd5, 32'h14, 30'h0, 32'h0, 0, 0, 0, 1, 0);
    play(4'd5, 32'h14, 30'h0, 32'h0);

    // intr at WB is taken
    build(4'd0, 32'h20, 30'h0, 32'h0, 0, 0, 1, 0, 0);
    chk("lit_intr_cycles", q.size(), 5);
    chk("lit_intr_epc", m_epc, 32'h20);
    chk("lit_intr_pc", m_pc, 32'h100);
    play(4'd0, 32'h20, 30'h0, 32'h0);

    // second interrupt is masked by intr_en=0
    build(4'd2, 32'h104, 30'h0, 32'h0, 0, 0, 1, 0, 0);
    chk("lit_masked_cycles", q.size(), 4);
    play(4'd2, 32'h104, 30'h0, 32'h0);

    // PC near the top of the address space, then wrap to 0
    build(4'd6, 32'hFFFF_FFFE, 30'h0, 32'h0, 0, 0, 0, 0, 0);
    play(4'd6, 32'hFFFF_FFFE, 30'h0, 32'h0);
    build(4'd7, 32'h0, 30'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("lit_wrap_addr", {2'b0, q[0].mem_addr}, 32'h3FFF_FFFF);
    play(4'd7, 32'h0, 30'h0, 32'h0);

    // reset while a lw waits for ack in MEM
    build(4'd4, 32'h30, 30'h55, 32'h0, 0, 0, 0, 0, 2);
    play(4'd4, 32'h30, 30'h55, 32'h0);
    do_reset();
    build(4'd1, 32'h4, 30'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("lit_post_rst_addr", {2'b0, q[0].mem_addr}, 32'h0);
    chk("lit_post_rst_ien", {31'h0, q[0].intr_en}, 32'h1);
    play(4'd1, 32'h4, 30'h0, 32'h0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-002 Parameter INTR_VEC, default 32'h0000_0100: PC loaded on interrupt entry.
REQ-003 clk  in  1  the only clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 opcode  in  4  opcode field of the latched instruction register.
REQ-006 ex_pc  in  32  next PC computed by the ALU.
REQ-007 ex_addr  in  30  word address (addr_4byte) from the ALU.
REQ-008 ex_wdata  in  32  store data (mem_val) from the ALU.
REQ-009 mem_rdata  in  32  memory read data, valid when mem_ack=1.
REQ-010 mem_ack  in  1  memory completion; ignored when mem_req=0.
REQ-011 intr_req  in  1  level-sensitive interrupt request.
REQ-012 mem_req  out  1  memory request.
REQ-013 mem_we  out  1  write enable, qualified by mem_req.
REQ-014 mem_addr  out  30  word address.
REQ-015 mem_wdata  out  32  write data.
REQ-016 ir_en  out  1  load the instruction register from mem_rdata.
REQ-017 ld_en  out  1  load the mem_val register from mem_rdata.
REQ-018 rf_we  out  1  register-file write of x_rd.
REQ-019 pc  out  32  architectural PC.
REQ-020 epc  out  32  saved PC of the interrupted instruction.
REQ-021 intr_en  out  1  global interrupt enable.
REQ-022 state  out  3  current FSM state, for debug.

Function
REQ-023 The FSM has states FETCH, DECODE, EXEC, MEM, WB and INTR.
REQ-024 FETCH behaviour:
- Drives mem_req=1, mem_we=0, mem_addr=pc[31:2].
- When mem_ack=1, asserts ir_en in that cycle and moves to DECODE.
- Otherwise stays in FETCH.
REQ-025 DECODE always moves to EXEC after 1 cycle.
REQ-026 EXEC moves to MEM for opcode 3 (sw) or 4 (lw); for every other opcode it moves to WB.
REQ-027 MEM behaviour:
- Drives mem_req=1, mem_addr=ex_addr, and mem_we=1 for sw.
- Drives mem_wdata=ex_wdata.
- On mem_ack, asserts ld_en for lw and moves to WB; otherwise stays in MEM.
REQ-028 While mem_req=1, mem_addr, mem_we and mem_wdata are held stable until the acking cycle.
REQ-029 mem_req deasserts in the cycle after mem_ack, with no back-to-back request from the same state.
REQ-030 WB behaviour:
- Updates pc<=ex_pc.
- Asserts rf_we for opcodes 0, 1, 2, 4, 5 and 6.
- Holds rf_we=0 for opcode 3 and for opcodes 7-F, which are treated as nop.
REQ-031 On leaving WB, if intr_en=1 and intr_req=1, the next state is INTR; otherwise it is FETCH.
REQ-032 INTR lasts 1 cycle:
- epc<=ex_pc.
- pc<=INTR_VEC.
- intr_en<=0.
- Next state is FETCH.
REQ-033 Cycle counts with zero-wait memory (ack in the request cycle):
- ALU or jump instruction: 4 cycles.
- lw or sw: 5 cycles.
- Each extra wait cycle adds 1.
REQ-034 An intr_req that rises and falls entirely outside WB is not taken; the interrupt is level-sampled only at WB.
REQ-035 PC arithmetic wraps modulo 2^32; pc[1:0] is ignored for addressing.
REQ-036 All outputs not listed as active in a state are 0 in that state.

Reset
REQ-037 reset=1 at any clock edge forces all of the following, including in the middle of a memory transaction:
- state=FETCH, pc=RESET_PC, epc=0, intr_en=1.
- mem_req, ir_en, ld_en and rf_we are 0 for the reset cycle.
REQ-038 The first fetch request is issued in the first cycle after reset deasserts.

Structure
REQ-039 The state enum, opcode constants (OP_LIH=0 ... OP_JCC=6) and the rf_we opcode set reside in the shared CPU package.
REQ-040 The design is a single module with no sub-modules; the memory-port mux is inline.

Verification
REQ-041 Reset, then opcode=1 with zero-wait memory and ex_pc=4: mem_req at cycles 0, then WB at cycle 3; pc=4 and rf_we=1 for 1 cycle.
REQ-042 lw (opcode 4) with ex_addr=30'h10 and a 2-cycle ack delay in MEM: mem_addr=0x10 held stable, ld_en asserts in the ack cycle, 7 cycles total.
REQ-043 sw (opcode 3) with ex_wdata=32'hDEADBEEF: mem_we=1 and mem_wdata stable until ack; rf_we=0 in WB.
REQ-044 intr_req=1 during WB with ex_pc=0x20: next state INTR, epc=0x20, pc=0x100, intr_en=0; a second intr_req is not taken.
REQ-045 reset asserted while in MEM waiting for ack: next cycle state=FETCH, pc=RESET_PC, mem_req=1 for address 0.
REQ-046 opcode=4'hF: no MEM state is entered, rf_we=0, pc<=ex_pc.
